// File: rtl/processador_led_ctrl.sv
// processador_led_ctrl: Avalon-MM slave driving a WIDTH-bit LED port with
// direct/set/clear writes, per-bit blink and global PWM brightness.
module processador_led_ctrl #(
    parameter int WIDTH          = 8,
    parameter int PRESCALE_W     = 24,
    parameter int DEFAULT_PERIOD = 12_499_999,
    parameter int PWM_BITS       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]      data_q, data_d, blink_en_q, blink_en_d, out_q, out_d;
    logic [PRESCALE_W-1:0] period_q, period_d, blink_cnt_q, blink_cnt_d;
    logic [PWM_BITS-1:0]   bright_q, bright_d, pwm_cnt_q, pwm_cnt_d;
    logic                  phase_q, phase_d, pwm_on, wr;
    logic                  unused_wd;

    assign wr        = chipselect & ~write_n;
    assign pwm_on    = (bright_q == '1) | (pwm_cnt_q < bright_q);
    assign out_port  = out_q;
    assign unused_wd = ^writedata;

    always_comb begin
        data_d      = data_q;
        blink_en_d  = blink_en_q;
        period_d    = period_q;
        bright_d    = bright_q;
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        pwm_cnt_d   = pwm_cnt_q + 1'b1;
        if (blink_cnt_q == period_q) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
        // a PERIOD write restarts the blink cycle, overriding the terminal count
        if (wr) begin
            case (address)
                3'd0: data_d = writedata[WIDTH-1:0];
                3'd1: data_d = data_q | writedata[WIDTH-1:0];
                3'd2: data_d = data_q & ~writedata[WIDTH-1:0];
                3'd3: blink_en_d = writedata[WIDTH-1:0];
                3'd4: begin
                    period_d    = writedata[PRESCALE_W-1:0];
                    blink_cnt_d = '0;
                    phase_d     = 1'b1;
                end
                3'd5: bright_d = writedata[PWM_BITS-1:0];
                default: ;
            endcase
        end
        out_d = data_q & (~blink_en_q | {WIDTH{phase_q}}) & {WIDTH{pwm_on}};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q      <= '0;
            blink_en_q  <= '0;
            period_q    <= PRESCALE_W'(DEFAULT_PERIOD);
            bright_q    <= '1;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            pwm_cnt_q   <= '0;
            out_q       <= '0;
        end else begin
            data_q      <= data_d;
            blink_en_q  <= blink_en_d;
            period_q    <= period_d;
            bright_q    <= bright_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            pwm_cnt_q   <= pwm_cnt_d;
            out_q       <= out_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            3'd0: readdata[WIDTH-1:0] = data_q;
            3'd3: readdata[WIDTH-1:0] = blink_en_q;
            3'd4: readdata[PRESCALE_W-1:0] = period_q;
            3'd5: readdata[PWM_BITS-1:0] = bright_q;
            3'd6: begin
                readdata[0]               = phase_q;
                readdata[PWM_BITS+15:16]  = pwm_cnt_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_processador_led_ctrl.sv
// tb_processador_led_ctrl: directed checks of register access, blink, PWM
// and asynchronous reset of processador_led_ctrl.
`timescale 1ns/100ps
module tb_processador_led_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    int          cmp_cnt = 0;
    int          err_cnt = 0;

    localparam logic [31:0] DEF_PERIOD = 32'h00BE_BC1F;

    processador_led_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #10 clk = ~clk;

    // write lands on the posedge between two negedges; returns just after it
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        address = a;
        #1 v = readdata;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        logic [31:0] exp_rd [8];
        exp_rd = '{32'h0, 32'h0, 32'h0, 32'h0, DEF_PERIOD, 32'hFF, 32'h1, 32'h0};
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            cmp_cnt++;
            if (v !== exp_rd[i]) begin
                err_cnt++;
                $display("FAIL reset_rd%0d: got %h expected %h", i, v, exp_rd[i]);
            end
        end
        cmp_cnt++;
        if (out_port !== 8'h00) begin
            err_cnt++;
            $display("FAIL reset_out: got %h expected 00", out_port);
        end
    endtask

    task automatic test_data_set_clr;
        logic [31:0] v;
        logic [2:0]  addrs [3] = '{3'd0, 3'd1, 3'd2};
        logic [31:0] wds   [3] = '{32'hA5, 32'h0F, 32'h81};
        logic [7:0]  exps  [3] = '{8'hA5, 8'hAF, 8'h2E};
        logic [7:0]  prev = 8'h00;
        for (int i = 0; i < 3; i++) begin
            wr(addrs[i], wds[i]);
            rd(3'd0, v);
            cmp_cnt++;
            if (v !== {24'd0, exps[i]}) begin
                err_cnt++;
                $display("FAIL data_rd%0d: got %h expected %h", i, v, exps[i]);
            end
            cmp_cnt++;
            if (out_port !== prev) begin
                err_cnt++;
                $display("FAIL out_latency%0d: got %h expected %h", i, out_port, prev);
            end
            @(negedge clk);
            #1;
            cmp_cnt++;
            if (out_port !== exps[i]) begin
                err_cnt++;
                $display("FAIL out_follow%0d: got %h expected %h", i, out_port, exps[i]);
            end
            prev = exps[i];
        end
        rd(3'd1, v);
        cmp_cnt++;
        if (v !== 32'h0) begin
            err_cnt++;
            $display("FAIL set_reads0: got %h expected 0", v);
        end
        rd(3'd2, v);
        cmp_cnt++;
        if (v !== 32'h0) begin
            err_cnt++;
            $display("FAIL clr_reads0: got %h expected 0", v);
        end
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd7, v);
        cmp_cnt++;
        if (v !== 32'h0) begin
            err_cnt++;
            $display("FAIL reserved_rd: got %h expected 0", v);
        end
        rd(3'd0, v);
        cmp_cnt++;
        if (v !== 32'h2E) begin
            err_cnt++;
            $display("FAIL reserved_nodisturb: got %h expected 2e", v);
        end
    endtask

    task automatic test_blink;
        logic [31:0] v;
        logic        exp_phase;
        logic [7:0]  exp_out;
        wr(3'd0, 32'h03);
        wr(3'd3, 32'h01);
        wr(3'd4, 32'h03);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            rd(3'd6, v);
            exp_phase = ((i / 4) % 2) == 0;
            exp_out   = {6'd0, 1'b1, (((i - 1) / 4) % 2) == 0};
            cmp_cnt++;
            if (v[0] !== exp_phase) begin
                err_cnt++;
                $display("FAIL blink_phase%0d: got %b expected %b", i, v[0], exp_phase);
            end
            cmp_cnt++;
            if (out_port !== exp_out) begin
                err_cnt++;
                $display("FAIL blink_out%0d: got %h expected %h", i, out_port, exp_out);
            end
        end
    endtask

    task automatic test_pwm;
        int          hi, lo, bad;
        logic [31:0] brights [3] = '{32'h40, 32'h00, 32'hFF};
        int          exp_hi  [3] = '{64, 0, 256};
        wr(3'd3, 32'h00);
        wr(3'd0, 32'hFF);
        for (int b = 0; b < 3; b++) begin
            wr(3'd5, brights[b]);
            @(negedge clk);
            hi = 0; lo = 0; bad = 0;
            for (int i = 0; i < 256; i++) begin
                @(negedge clk);
                if (out_port === 8'hFF) hi++;
                else if (out_port === 8'h00) lo++;
                else bad++;
            end
            cmp_cnt++;
            if (hi !== exp_hi[b] || bad !== 0) begin
                err_cnt++;
                $display("FAIL pwm_duty%0d: got high=%0d other=%0d expected high=%0d other=0",
                         b, hi, bad, exp_hi[b]);
            end
        end
    endtask

    task automatic test_period_zero;
        logic [31:0] v;
        logic        exp_phase;
        wr(3'd0, 32'h01);
        wr(3'd3, 32'h01);
        wr(3'd4, 32'h05);
        repeat (3) @(negedge clk);
        wr(3'd4, 32'h00);
        rd(3'd6, v);
        cmp_cnt++;
        if (v[0] !== 1'b1) begin
            err_cnt++;
            $display("FAIL p0_phase0: got %b expected 1", v[0]);
        end
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            rd(3'd6, v);
            exp_phase = (j % 2) == 0;
            cmp_cnt++;
            if (v[0] !== exp_phase) begin
                err_cnt++;
                $display("FAIL p0_phase%0d: got %b expected %b", j, v[0], exp_phase);
            end
            cmp_cnt++;
            if (out_port[0] !== !exp_phase) begin
                err_cnt++;
                $display("FAIL p0_out%0d: got %b expected %b", j, out_port[0], !exp_phase);
            end
        end
        wr(3'd0, 32'hFFFF_FFFF);
        rd(3'd0, v);
        cmp_cnt++;
        if (v !== 32'h0000_00FF) begin
            err_cnt++;
            $display("FAIL data_trunc: got %h expected 000000ff", v);
        end
        wr(3'd4, 32'hFFFF_FFFF);
        rd(3'd4, v);
        cmp_cnt++;
        if (v !== 32'h00FF_FFFF) begin
            err_cnt++;
            $display("FAIL period_trunc: got %h expected 00ffffff", v);
        end
    endtask

    task automatic test_async_reset;
        logic [31:0] v;
        logic [31:0] exp_rd [7];
        exp_rd = '{32'h0, 32'h0, 32'h0, 32'h0, DEF_PERIOD, 32'hFF, 32'h1};
        wr(3'd3, 32'h00);
        wr(3'd0, 32'hFF);
        @(negedge clk);
        #1;
        cmp_cnt++;
        if (out_port !== 8'hFF) begin
            err_cnt++;
            $display("FAIL prereset_out: got %h expected ff", out_port);
        end
        #2 reset_n = 1'b0;
        #1;
        cmp_cnt++;
        if (out_port !== 8'h00) begin
            err_cnt++;
            $display("FAIL async_out: got %h expected 00", out_port);
        end
        for (int i = 0; i < 7; i++) begin
            rd(3'(i), v);
            cmp_cnt++;
            if (v !== exp_rd[i]) begin
                err_cnt++;
                $display("FAIL async_rd%0d: got %h expected %h", i, v, exp_rd[i]);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_data_set_clr();
        test_blink();
        test_pwm();
        test_period_zero();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
